// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_pkg
//  Brief    : Shared types and constants for the instruction prefetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int INSTR_STRIDE   = DEF_DATA_WIDTH / 8;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Byte distance between consecutive instruction words.
    function automatic int byte_stride(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_unit_if
//  Brief    : Instruction-side Wishbone classic bus bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_ack_i;
    logic [ADDR_WIDTH-1:0]     wb_adr_o;
    logic [DATA_WIDTH-1:0]     wb_dat_o;
    logic [DATA_WIDTH-1:0]     wb_dat_i;
    logic [DATA_WIDTH/8-1:0]   wb_sel_o;
    logic                      wb_we_o;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        output wb_ack_i, wb_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : if_fifo
//  Brief    : Synchronous first-word-fall-through FIFO with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       clear,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [WIDTH-1:0]                head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Clear wins over a same-cycle push or pop; storage contents are left stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_unit
//  Brief    : Sequential Wishbone instruction fetch feeding a prefetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  redirect_i,
    input  wire logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                       out_valid_o,
    input  wire logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_instr_o,
    output logic [ADDR_WIDTH-1:0]      out_pc_o,
    output logic                       busy_o,
    if_prefetch_unit_if.master         wb
);
    localparam int STRIDE = byte_stride(DATA_WIDTH);
    localparam int SEL_W  = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W  = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_t          r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
    logic                  r_cyc, w_cyc_next;
    logic                  r_stb, w_stb_next;
    logic [ADDR_WIDTH-1:0] r_adr, w_adr_next;
    logic [SEL_W-1:0]      r_sel, w_sel_next;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [ENT_W-1:0]      w_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_adr      <= '0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_cyc      <= w_cyc_next;
            r_stb      <= w_stb_next;
            r_adr      <= w_adr_next;
            r_sel      <= w_sel_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_cyc_next      = r_cyc;
        w_stb_next      = r_stb;
        w_adr_next      = r_adr;
        w_sel_next      = r_sel;
        w_push          = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (redirect_i) begin
                    w_fetch_pc_next = redirect_pc_i;
                end else if (w_count < CNT_W'(FIFO_DEPTH)) begin
                    w_state_next = READ;
                    w_cyc_next   = 1'b1;
                    w_stb_next   = 1'b1;
                    w_sel_next   = '1;
                    w_adr_next   = r_fetch_pc;
                end
            end
            READ: begin
                if (redirect_i) begin
                    w_fetch_pc_next = redirect_pc_i;
                    // Without an ack the bus cycle must be finished in DRAIN.
                    if (wb.wb_ack_i) begin
                        w_state_next = IDLE;
                        w_cyc_next   = 1'b0;
                        w_stb_next   = 1'b0;
                        w_sel_next   = '0;
                    end else begin
                        w_state_next = DRAIN;
                    end
                end else if (wb.wb_ack_i) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(STRIDE);
                    w_state_next    = IDLE;
                    w_cyc_next      = 1'b0;
                    w_stb_next      = 1'b0;
                    w_sel_next      = '0;
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    w_fetch_pc_next = redirect_pc_i;
                end
                if (wb.wb_ack_i) begin
                    w_state_next = IDLE;
                    w_cyc_next   = 1'b0;
                    w_stb_next   = 1'b0;
                    w_sel_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cyc_next   = 1'b0;
                w_stb_next   = 1'b0;
                w_sel_next   = '0;
            end
        endcase
    end

    if_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (out_ready_i),
        .clear   (redirect_i),
        .wdata   ({r_fetch_pc, wb.wb_dat_i}),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count),
        .head    (w_head)
    );

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!reset_n) !(w_push && w_full)
    );

    assign out_valid_o = !w_empty;
    assign out_pc_o    = w_head[ENT_W-1:DATA_WIDTH];
    assign out_instr_o = w_head[DATA_WIDTH-1:0];
    assign busy_o      = (r_state != IDLE);

    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_stb;
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_sel_o = r_sel;
    assign wb.wb_dat_o = '0;
    assign wb.wb_we_o  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_unit
//  Brief    : Directed self-checking bench for the instruction prefetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave control and bookkeeping
    int          ack_delay = 0;
    bit          ack_now   = 1'b0;
    int          wait_cnt  = 0;
    bit          seen      = 1'b0;
    int          issued_cnt = 0;
    logic [31:0] last_adr  = '0;

    if_prefetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbif ();

    if_prefetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .busy_o        (busy_o),
        .wb            (wbif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory slave: responds on the falling edge so the DUT samples cleanly.
    always @(negedge clk) begin
        if (!reset_n) begin
            wbif.wb_ack_i = 1'b0;
            wbif.wb_dat_i = '0;
            wait_cnt      = 0;
            seen          = 1'b0;
            issued_cnt    = 0;
        end else if (!wbif.wb_cyc_o || !wbif.wb_stb_o) begin
            wbif.wb_ack_i = 1'b0;
            wait_cnt      = 0;
            seen          = 1'b0;
        end else if (wbif.wb_ack_i) begin
            wbif.wb_ack_i = 1'b0;
        end else begin
            if (!seen) begin
                seen       = 1'b1;
                issued_cnt = issued_cnt + 1;
                last_adr   = wbif.wb_adr_o;
            end
            if ((ack_delay < 0) ? ack_now : (wait_cnt >= ack_delay)) begin
                wbif.wb_ack_i = 1'b1;
                wbif.wb_dat_i = img(wbif.wb_adr_o);
                wait_cnt      = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        out_ready_i   = 1'b0;
        ack_delay     = 0;
        ack_now       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_cyc_stb_we: got %b expected 000", {wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o});
        end
        n_checks++;
        if (wbif.wb_sel_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_sel: got %h expected 0", wbif.wb_sel_o);
        end
        n_checks++;
        if (wbif.wb_adr_o !== 32'h0 || wbif.wb_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_adr_dat: got adr %h dat %h expected 0", wbif.wb_adr_o, wbif.wb_dat_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy: got %b%b expected 00", out_valid_o, busy_o);
        end
        n_checks++;
        if (out_pc_o !== 32'h0 || out_instr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_head: got pc %h instr %h expected 0", out_pc_o, out_instr_o);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        int got;
        apply_reset();
        out_ready_i = 1'b1;
        exp_pc = RST_PC;
        got = 0;
        for (int t = 0; t < 200 && got < 6; t++) begin
            if (out_valid_o) begin
                n_checks++;
                if (out_pc_o !== exp_pc || out_instr_o !== img(exp_pc)) begin
                    n_fail++; $display("FAIL seq_entry%0d: got pc %h instr %h expected pc %h instr %h", got, out_pc_o, out_instr_o, exp_pc, img(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            step();
        end
        n_checks++;
        if (got != 6) begin
            n_fail++; $display("FAIL seq_count: got %0d entries expected 6", got);
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (40) step();
        n_checks++;
        if (issued_cnt != 4 || wbif.wb_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_full_stop: got %0d reads cyc %b expected 4 reads cyc 0", issued_cnt, wbif.wb_cyc_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== RST_PC) begin
            n_fail++; $display("FAIL bp_head: got valid %b pc %h expected 1 %h", out_valid_o, out_pc_o, RST_PC);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        repeat (20) step();
        n_checks++;
        if (issued_cnt != 5 || last_adr !== RST_PC + 32'd16) begin
            n_fail++; $display("FAIL bp_refill: got %0d reads last %h expected 5 reads last %h", issued_cnt, last_adr, RST_PC + 32'd16);
        end
        n_checks++;
        if (out_pc_o !== RST_PC + 32'd4 || wbif.wb_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_after_pop: got pc %h cyc %b expected %h 0", out_pc_o, wbif.wb_cyc_o, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_read();
        bit ok;
        apply_reset();
        ack_delay = 3;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (out_valid_o && wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rdr_setup: got timeout expected second read with one entry queued");
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || wbif.wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rdr_drain: got valid %b cyc %b busy %b expected 0 1 1", out_valid_o, wbif.wb_cyc_o, busy_o);
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (!wbif.wb_cyc_o) begin ok = 1'b1; break; end
            step();
        end
        ack_delay = 0;
        n_checks++;
        if (!ok || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rdr_dropped: got cyc_dropped %b valid %b expected 1 0", ok, out_valid_o);
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || wbif.wb_adr_o !== 32'h8000_0100) begin
            n_fail++; $display("FAIL rdr_target: got adr %h expected 80000100", wbif.wb_adr_o);
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || out_pc_o !== 32'h8000_0100 || out_instr_o !== img(32'h8000_0100)) begin
            n_fail++; $display("FAIL rdr_entry: got pc %h instr %h expected 80000100 %h", out_pc_o, out_instr_o, img(32'h8000_0100));
        end
    endtask

    task automatic test_redirect_ack();
        bit ok;
        apply_reset();
        ack_delay = -1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0200;
        ack_now       = 1'b1;
        step();
        redirect_i = 1'b0;
        ack_now    = 1'b0;
        n_checks++;
        if (!ok || out_valid_o !== 1'b0 || wbif.wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rda_no_push: got valid %b cyc %b busy %b expected 0 0 0", out_valid_o, wbif.wb_cyc_o, busy_o);
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || wbif.wb_adr_o !== 32'h8000_0200) begin
            n_fail++; $display("FAIL rda_target: got adr %h expected 80000200", wbif.wb_adr_o);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0300;
        step();
        n_checks++;
        if (busy_o !== 1'b1 || wbif.wb_cyc_o !== 1'b1) begin
            n_fail++; $display("FAIL rda_in_drain: got busy %b cyc %b expected 1 1", busy_o, wbif.wb_cyc_o);
        end
        redirect_pc_i = 32'h8000_0380;
        step();
        redirect_i = 1'b0;
        ack_now    = 1'b1;
        step();
        ack_now = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || wbif.wb_adr_o !== 32'h8000_0380 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rda_latest: got adr %h valid %b expected 80000380 0", wbif.wb_adr_o, out_valid_o);
        end
        ack_delay = 0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || out_pc_o !== 32'h8000_0380) begin
            n_fail++; $display("FAIL rda_entry: got pc %h expected 80000380", out_pc_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] exp_pc;
        int got;
        apply_reset();
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (wbif.wb_stb_o && wbif.wb_adr_o == RST_PC + 32'd8) begin ok = 1'b1; break; end
            step();
        end
        // Two entries queued; the third ack and this pop land on the same edge.
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_checks++;
        if (!ok || out_valid_o !== 1'b1 || out_pc_o !== RST_PC + 32'd4) begin
            n_fail++; $display("FAIL b2b_head: got valid %b pc %h expected 1 %h", out_valid_o, out_pc_o, RST_PC + 32'd4);
        end
        repeat (30) step();
        n_checks++;
        if (issued_cnt != 5) begin
            n_fail++; $display("FAIL b2b_count: got %0d reads expected 5", issued_cnt);
        end
        out_ready_i = 1'b1;
        exp_pc = RST_PC + 32'd4;
        got = 0;
        for (int t = 0; t < 400 && got < 12; t++) begin
            if (out_valid_o) begin
                n_checks++;
                if (out_pc_o !== exp_pc || out_instr_o !== img(exp_pc)) begin
                    n_fail++; $display("FAIL b2b_order%0d: got pc %h instr %h expected pc %h instr %h", got, out_pc_o, out_instr_o, exp_pc, img(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            step();
        end
        n_checks++;
        if (got != 12) begin
            n_fail++; $display("FAIL b2b_wrap_count: got %0d entries expected 12", got);
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            step();
        end
        ack_delay = 8;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) break;
            step();
        end
        n_checks++;
        if (!ok || busy_o !== 1'b1 || wbif.wb_cyc_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_setup: got valid_seen %b busy %b cyc %b expected 1 1 1", ok, busy_o, wbif.wb_cyc_o);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (wbif.wb_cyc_o !== 1'b0 || wbif.wb_stb_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_async: got cyc %b stb %b valid %b busy %b expected 0 0 0 0", wbif.wb_cyc_o, wbif.wb_stb_o, out_valid_o, busy_o);
        end
        step();
        step();
        reset_n   = 1'b1;
        ack_delay = 0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (wbif.wb_stb_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || wbif.wb_adr_o !== RST_PC) begin
            n_fail++; $display("FAIL rst_mid_restart: got adr %h expected %h", wbif.wb_adr_o, RST_PC);
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            step();
        end
        n_checks++;
        if (!ok || out_pc_o !== RST_PC || out_instr_o !== img(RST_PC)) begin
            n_fail++; $display("FAIL rst_mid_entry: got pc %h instr %h expected %h %h", out_pc_o, out_instr_o, RST_PC, img(RST_PC));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_read();
        test_redirect_ack();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
